// File: rtl/func_eval.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : func_eval
// Description : Registered 4-input Boolean function evaluator built as a
//               16-entry truth-table lookup, f = table_q[{w,x,y,z}].
//               The table resets to TRUTH_TABLE and can be reloaded at run
//               time through tbl_we/tbl_data.
//               Optional macro FUNC_COMB_OUT_EN adds the combinational
//               lookup output f_comb.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module func_eval #(
   parameter logic [15:0] TRUTH_TABLE = 16'h0727
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        w,
   input  logic        x,
   input  logic        y,
   input  logic        z,
   input  logic        in_valid,
   input  logic        tbl_we,
   input  logic [15:0] tbl_data,
   output logic        f,
   output logic        out_valid,
   output logic [15:0] table_q
`ifdef FUNC_COMB_OUT_EN
   ,
   output logic        f_comb
`endif
);

   logic [15:0] r_table;
   logic        r_f;
   logic        r_out_valid;
   logic [3:0]  w_idx;
   logic        w_lookup;

   // Index is {w,x,y,z} with w as the MSB; lookup uses the current (pre-edge) table
   always_comb begin
      w_idx    = {w, x, y, z};
      w_lookup = r_table[w_idx];
   end

   // Table storage: reset default, overwritten wholesale on tbl_we
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_table <= TRUTH_TABLE;
      end else if (tbl_we) begin
         r_table <= tbl_data;
      end
   end

   // Result register: capture only on accepted inputs so idle-cycle X/Z never reaches state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_f         <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_f <= w_lookup;
         end
      end
   end

   assign f         = r_f;
   assign out_valid = r_out_valid;
   assign table_q   = r_table;

`ifdef FUNC_COMB_OUT_EN
   // Ungated combinational view of the lookup
   assign f_comb = w_lookup;
`endif

endmodule
`default_nettype wire

// File: tb/tb_func_eval.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_func_eval
// Description : Directed self-checking bench for func_eval.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_func_eval;

   logic        clk;
   logic        rst;
   logic        w, x, y, z;
   logic        in_valid;
   logic        tbl_we;
   logic [15:0] tbl_data;
   logic        f;
   logic        out_valid;
   logic [15:0] table_q;
`ifdef FUNC_COMB_OUT_EN
   logic        f_comb;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // Hand-computed values of x'y' + x'z' + w'xy'z for idx 0..15
   bit exp_sweep [16] = '{1,1,1,0,0,1,0,0,1,1,1,0,0,0,0,0};

   func_eval #(.TRUTH_TABLE(16'h0727)) dut (
      .clk      (clk),
      .rst      (rst),
      .w        (w),
      .x        (x),
      .y        (y),
      .z        (z),
      .in_valid (in_valid),
      .tbl_we   (tbl_we),
      .tbl_data (tbl_data),
      .f        (f),
      .out_valid(out_valid),
      .table_q  (table_q)
`ifdef FUNC_COMB_OUT_EN
      ,
      .f_comb   (f_comb)
`endif
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, then sample just after the rising edge
   task automatic step(input logic [3:0] idx, input logic v, input logic we, input logic [15:0] d);
      @(negedge clk);
      {w, x, y, z} = idx;
      in_valid     = v;
      tbl_we       = we;
      tbl_data     = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; {w, x, y, z} = 4'h0; in_valid = 1'b0; tbl_we = 1'b0; tbl_data = 16'h0000;

      // Asynchronous reset before any clock edge
      #1 rst = 1'b1;
      #1;
      check("rst_f",         {15'd0, f},         16'd0);
      check("rst_out_valid", {15'd0, out_valid}, 16'd0);
      check("rst_table",     table_q,            16'h0727);
      @(negedge clk);
      rst = 1'b0;

      // Exhaustive sweep of the default table
      for (int i = 0; i < 16; i++) begin
         step(i[3:0], 1'b1, 1'b0, 16'h0000);
         check($sformatf("sweep_f_%0d", i),  {15'd0, f},         {15'd0, exp_sweep[i]});
         check($sformatf("sweep_ov_%0d", i), {15'd0, out_valid}, 16'd1);
      end

      // Valid gating: f holds and out_valid drops when in_valid=0
      step(4'd0, 1'b1, 1'b0, 16'h0000);
      check("gate_pre_f", {15'd0, f}, 16'd1);
      step(4'd3, 1'b0, 1'b0, 16'h0000);
      check("gate_f",  {15'd0, f},         16'd1);
      check("gate_ov", {15'd0, out_valid}, 16'd0);

      // Unknown inputs while idle must not disturb state
      @(negedge clk);
      {w, x, y, z} = 4'bxxxx;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("xidle_f",     {15'd0, f},         16'd1);
      check("xidle_ov",    {15'd0, out_valid}, 16'd0);
      check("xidle_table", table_q,            16'h0727);

      // Reload with a simultaneous lookup: old table applies (0727 bit15 = 0)
      step(4'd15, 1'b1, 1'b1, 16'h8001);
      check("reload_f_old", {15'd0, f},         16'd0);
      check("reload_ov",    {15'd0, out_valid}, 16'd1);
      check("reload_table", table_q,            16'h8001);
      step(4'd15, 1'b1, 1'b0, 16'h0000);
      check("new_f_15", {15'd0, f}, 16'd1);
      step(4'd5, 1'b1, 1'b0, 16'h0000);
      check("new_f_5", {15'd0, f}, 16'd0);
      step(4'd0, 1'b1, 1'b0, 16'h0000);
      check("new_f_0", {15'd0, f}, 16'd1);

      // Reload to all-ones (lookup at idx 3 sees 8001 -> 0), then use it
      step(4'd3, 1'b1, 1'b1, 16'hFFFF);
      check("ffff_f_old", {15'd0, f}, 16'd0);
      step(4'd3, 1'b1, 1'b0, 16'h0000);
      check("ffff_f_3", {15'd0, f},         16'd1);
      check("ffff_ov",  {15'd0, out_valid}, 16'd1);

      // Reset pulse between edges discards result and restores default table
      @(negedge clk);
      in_valid = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("midrst_table", table_q,            16'h0727);
      check("midrst_ov",    {15'd0, out_valid}, 16'd0);
      check("midrst_f",     {15'd0, f},         16'd0);
      rst = 1'b0;
      step(4'd3, 1'b1, 1'b0, 16'h0000);
      check("postrst_f_3",  {15'd0, f},         16'd0);
      check("postrst_ov",   {15'd0, out_valid}, 16'd1);
      step(4'd5, 1'b1, 1'b0, 16'h0000);
      check("postrst_f_5",  {15'd0, f},         16'd1);

`ifdef FUNC_COMB_OUT_EN
      // Combinational output follows idx within the cycle, ungated by in_valid
      step(4'd3, 1'b1, 1'b0, 16'h0000);
      @(negedge clk);
      {w, x, y, z} = 4'd5;
      in_valid = 1'b0;
      #1;
      check("comb_f_comb", {15'd0, f_comb},    16'd1);
      check("comb_f",      {15'd0, f},         16'd0);
      check("comb_ov",     {15'd0, out_valid}, 16'd1);
      {w, x, y, z} = 4'd3;
      #1;
      check("comb_f_comb_3", {15'd0, f_comb}, 16'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
